// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: shared AHB encodings and bridge state type.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR1  = 3'd4,
    S_ERR2  = 3'd5
  } state_e;

  // True for transfer types that carry a real access.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic active;
    active = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      default: active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: maps an AHB address onto one of NUM_SLV equal-size APB slots.
module ahb_addr_decode
  import ahb_bridge_pkg::*;
#(
  parameter int          NUM_SLV    = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          SLOT_SHIFT = 26
) (
  input  logic [31:0]        haddr,
  output logic               mapped,
  output logic [NUM_SLV-1:0] sel
);

  // Upper bound kept in 33 bits so a region ending at 4 GB does not wrap to 0.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(NUM_SLV) << SLOT_SHIFT);

  logic [32:0] offset;
  logic [32:0] slot;

  // Range check and one-hot slot select.
  always_comb begin
    offset = {1'b0, haddr} - {1'b0, BASE_ADDR};
    mapped = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr} < LIMIT);
    slot   = offset >> SLOT_SHIFT;
    sel    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = mapped && (slot == 33'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_pipe.sv
// ahb_slave_pipe: AHB slave front end that turns AHB transfers into a single
// outstanding request for an APB master FSM, with registered AHB responses.
module ahb_slave_pipe
  import ahb_bridge_pkg::*;
#(
  parameter int          NUM_SLV    = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          SLOT_SHIFT = 26,
  parameter int          DATA_W     = 32,
  parameter int          TIMEOUT    = 255
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               Hreadyin,
  input  logic               Hwrite,
  input  logic [1:0]         Htrans,
  input  logic [31:0]        Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  output logic               req_valid,
  output logic               req_write,
  output logic [31:0]        req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  output logic [NUM_SLV-1:0] req_sel,
  input  logic               apb_done,
  input  logic               apb_err,
  input  logic [DATA_W-1:0]  apb_rdata
);

  // Last count value spent in S_WAIT before giving up.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                hreadyout_q, hreadyout_d;
  logic [1:0]          hresp_q, hresp_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic                req_valid_q, req_valid_d;
  logic                req_write_q, req_write_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [NUM_SLV-1:0]  req_sel_q, req_sel_d;
  logic                accept;
  logic                dec_mapped;
  logic [NUM_SLV-1:0]  dec_sel;

  ahb_addr_decode #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_SHIFT(SLOT_SHIFT)
  ) u_decode (
    .haddr (Haddr),
    .mapped(dec_mapped),
    .sel   (dec_sel)
  );

  // Next-state, request capture and registered-response computation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hrdata_d    = hrdata_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_sel_d   = req_sel_q;
    accept      = Hreadyin && htrans_active(Htrans);

    case (state_q)
      S_IDLE, S_RESP, S_ERR2: begin
        if (accept && dec_mapped) begin
          req_addr_d  = Haddr;
          req_write_d = Hwrite;
          req_sel_d   = dec_sel;
          cnt_d       = '0;
          state_d     = Hwrite ? S_WDATA : S_WAIT;
        end else if (accept) begin
          state_d = S_ERR1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        // Write data arrives in the data phase, one cycle after the address.
        req_wdata_d = Hwdata;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A completion in the same cycle as the timeout wins.
        if (apb_done && !apb_err) begin
          state_d = S_RESP;
          if (!req_write_q) begin
            hrdata_d = apb_rdata;
          end
        end else if (apb_done) begin
          state_d = S_ERR1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Response outputs are a pure function of the state being entered.
    hreadyout_d = !(state_d == S_WDATA || state_d == S_WAIT || state_d == S_ERR1);
    hresp_d     = (state_d == S_ERR1 || state_d == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    req_valid_d = (state_d == S_WAIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Hclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (Hreset) begin
      // NOTE: reset is synchronous; a completion seen during reset is dropped
      // because the state is forced to S_IDLE, not S_WAIT.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_sel_q   <= req_sel_d;
    end
  end

  assign Hreadyout = hreadyout_q;
  assign Hresp     = hresp_q;
  assign Hrdata    = hrdata_q;
  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_sel   = req_sel_q;

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// tb_ahb_slave_pipe: table-driven and randomized checks of the AHB slave pipe.
module tb_ahb_slave_pipe;
  import ahb_bridge_pkg::*;

  localparam int          NUM_SLV = 3;
  localparam int          TMO     = 4;
  localparam logic [31:0] BASE    = 32'h8000_0000;

  logic               Hclk;
  logic               Hreset;
  logic               Hreadyin;
  logic               Hwrite;
  logic [1:0]         Htrans;
  logic [31:0]        Haddr;
  logic [31:0]        Hwdata;
  logic               Hreadyout;
  logic [1:0]         Hresp;
  logic [31:0]        Hrdata;
  logic               req_valid;
  logic               req_write;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [NUM_SLV-1:0] req_sel;
  logic               apb_done;
  logic               apb_err;
  logic [31:0]        apb_rdata;

  ahb_slave_pipe #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE),
    .SLOT_SHIFT(26),
    .DATA_W    (32),
    .TIMEOUT   (TMO)
  ) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .Hreadyin (Hreadyin),
    .Hwrite   (Hwrite),
    .Htrans   (Htrans),
    .Haddr    (Haddr),
    .Hwdata   (Hwdata),
    .Hreadyout(Hreadyout),
    .Hresp    (Hresp),
    .Hrdata   (Hrdata),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_sel  (req_sel),
    .apb_done (apb_done),
    .apb_err  (apb_err),
    .apb_rdata(apb_rdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  typedef struct {
    bit                 mapped;
    logic [NUM_SLV-1:0] sel;
    int                 first;   // cycle after accept where req_valid first rises
    int                 nv;      // number of req_valid cycles
    int                 low;     // number of Hreadyout=0 cycles
    logic [1:0]         resp;
    logic [31:0]        hrdata;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          write;
    logic [31:0] wdata;
    int          delay;          // req_valid cycles before apb_done; -1 = never
    bit          err;
    logic [31:0] rdata;
    exp_t        exp;
  } vec_t;

  typedef struct {
    bit                 timed_out;
    int                 first;
    int                 nv;
    int                 low;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_write;
    logic [NUM_SLV-1:0] r_sel;
    logic [1:0]         last_low_resp;
    logic [1:0]         resp;
    logic [31:0]        hrdata;
  } obs_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] hrdata_model;
  vec_t        vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome derived from the address map and
  // the latency/timeout rules, with no notion of internal states.
  function automatic exp_t model(input logic [31:0] addr, input bit write, input int delay,
                                 input bit err, input logic [31:0] rdata,
                                 input logic [31:0] prev_hrdata);
    exp_t    e;
    longint  a;
    longint  base;
    longint  top;
    bit      tmo;
    int      wait_n;
    a        = longint'({32'd0, addr});
    base     = longint'({32'd0, BASE});
    top      = base + longint'(NUM_SLV) * (64'sd1 <<< 26);
    e.mapped = (a >= base) && (a < top);
    e.hrdata = prev_hrdata;
    if (!e.mapped) begin
      e.sel = '0; e.first = 0; e.nv = 0; e.low = 1; e.resp = HRESP_ERROR;
    end else begin
      e.sel   = NUM_SLV'(1) << ((a - base) >>> 26);
      tmo     = (delay < 0) || (delay >= TMO);
      wait_n  = tmo ? TMO : delay + 1;
      e.first = write ? 2 : 1;
      e.nv    = wait_n;
      e.low   = (write ? 1 : 0) + wait_n + ((tmo || err) ? 1 : 0);
      e.resp  = (tmo || err) ? HRESP_ERROR : HRESP_OKAY;
      if (!write && !tmo && !err) e.hrdata = rdata;
    end
    return e;
  endfunction

  task automatic drive_addr(input logic [31:0] addr, input bit write, input logic [1:0] trans);
    Haddr    = addr;
    Hwrite   = write;
    Htrans   = trans;
    Hreadyin = 1'b1;
  endtask

  // Runs the data phase; returns at the cycle where Hreadyout is seen high.
  task automatic run_data(input logic [31:0] wdata, input int delay, input bit err,
                          input logic [31:0] rdata, output obs_t o);
    o.timed_out = 1'b0; o.first = 0; o.nv = 0; o.low = 0;
    o.r_addr = '0; o.r_wdata = '0; o.r_write = 1'b0; o.r_sel = '0;
    o.last_low_resp = HRESP_OKAY; o.resp = HRESP_OKAY; o.hrdata = '0;
    @(posedge Hclk); #1;
    Htrans = HTRANS_IDLE;
    Hwdata = wdata;
    for (int c = 1; c <= 40; c++) begin
      if (Hreadyout === 1'b1) begin
        o.resp   = Hresp;
        o.hrdata = Hrdata;
        o.low    = c - 1;
        apb_done = 1'b0;
        return;
      end
      o.last_low_resp = Hresp;
      apb_done = 1'b0;
      if (req_valid === 1'b1) begin
        if (o.nv == 0) begin
          o.first   = c;
          o.r_addr  = req_addr;
          o.r_wdata = req_wdata;
          o.r_write = req_write;
          o.r_sel   = req_sel;
        end
        apb_done  = (o.nv == delay);
        apb_err   = err;
        apb_rdata = rdata;
        o.nv++;
      end
      @(posedge Hclk); #1;
    end
    o.timed_out = 1'b1;
    apb_done    = 1'b0;
  endtask

  task automatic compare_obs(input string name, input obs_t o, input exp_t e,
                             input logic [31:0] addr, input bit write, input logic [31:0] wdata);
    check({name, " bound"},     64'(o.timed_out), 64'(0));
    check({name, " nvalid"},    64'(o.nv), 64'(e.nv));
    check({name, " lowcyc"},    64'(o.low), 64'(e.low));
    check({name, " hresp"},     64'(o.resp), 64'(e.resp));
    check({name, " hresp_low"}, 64'(o.last_low_resp), 64'(e.resp));
    check({name, " hrdata"},    64'(o.hrdata), 64'(e.hrdata));
    if (e.mapped) begin
      check({name, " first"},     64'(o.first), 64'(e.first));
      check({name, " req_sel"},   64'(o.r_sel), 64'(e.sel));
      check({name, " req_addr"},  64'(o.r_addr), 64'(addr));
      check({name, " req_write"}, 64'(o.r_write), 64'(write));
      if (write) check({name, " req_wdata"}, 64'(o.r_wdata), 64'(wdata));
    end
  endtask

  task automatic do_xfer(input string name, input logic [31:0] addr, input bit write,
                         input logic [1:0] trans, input logic [31:0] wdata, input int delay,
                         input bit err, input logic [31:0] rdata, input exp_t e);
    obs_t o;
    drive_addr(addr, write, trans);
    run_data(wdata, delay, err, rdata, o);
    compare_obs(name, o, e, addr, write, wdata);
    Htrans = HTRANS_IDLE;
    @(posedge Hclk); #1;
    check({name, " idle"}, 64'({Hreadyout, Hresp, req_valid}), 64'({1'b1, HRESP_OKAY, 1'b0}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    exp_t        e;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] edges [6];
    bit          write;
    bit          err;
    int          delay;
    logic [1:0]  trans;

    vecs[0] = '{"rd_slot1",   32'h8400_0010, 1'b0, 32'h0,         3, 1'b0, 32'hDEAD_BEEF,
                '{1'b1, 3'b010, 1, 4, 4, HRESP_OKAY,  32'hDEAD_BEEF}};
    vecs[1] = '{"wr_slot2",   32'h8800_0004, 1'b1, 32'h1234_5678, 1, 1'b0, 32'h0,
                '{1'b1, 3'b100, 2, 2, 3, HRESP_OKAY,  32'hDEAD_BEEF}};
    vecs[2] = '{"unmap_hi",   32'h8C00_0000, 1'b0, 32'h0,         0, 1'b0, 32'h0,
                '{1'b0, 3'b000, 0, 0, 1, HRESP_ERROR, 32'hDEAD_BEEF}};
    vecs[3] = '{"unmap_lo",   32'h7FFF_FFFC, 1'b1, 32'hAAAA_AAAA, 0, 1'b0, 32'h0,
                '{1'b0, 3'b000, 0, 0, 1, HRESP_ERROR, 32'hDEAD_BEEF}};
    vecs[4] = '{"unmap_top",  32'hFFFF_FFFC, 1'b0, 32'h0,         0, 1'b0, 32'h0,
                '{1'b0, 3'b000, 0, 0, 1, HRESP_ERROR, 32'hDEAD_BEEF}};
    vecs[5] = '{"rd_timeout", 32'h8000_0000, 1'b0, 32'h0,        -1, 1'b0, 32'h1111_1111,
                '{1'b1, 3'b001, 1, 4, 5, HRESP_ERROR, 32'hDEAD_BEEF}};
    vecs[6] = '{"rd_apb_err", 32'h83FF_FFFC, 1'b0, 32'h0,         0, 1'b1, 32'h5555_5555,
                '{1'b1, 3'b001, 1, 1, 2, HRESP_ERROR, 32'hDEAD_BEEF}};
    vecs[7] = '{"rd_top",     32'h8BFF_FFFC, 1'b0, 32'h0,         0, 1'b0, 32'hCAFE_F00D,
                '{1'b1, 3'b100, 1, 1, 1, HRESP_OKAY,  32'hCAFE_F00D}};
    vecs[8] = '{"wr_timeout", 32'h8400_0000, 1'b1, 32'h0BAD_F00D, 5, 1'b0, 32'h0,
                '{1'b1, 3'b010, 2, 4, 6, HRESP_ERROR, 32'hCAFE_F00D}};
    vecs[9] = '{"wr_apb_err", 32'h8000_0008, 1'b1, 32'hFEED_FACE, 2, 1'b1, 32'h0,
                '{1'b1, 3'b001, 2, 3, 5, HRESP_ERROR, 32'hCAFE_F00D}};

    edges[0] = 32'h7FFF_FFFC; edges[1] = 32'h8000_0000; edges[2] = 32'h8BFF_FFFC;
    edges[3] = 32'h8C00_0000; edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h0000_0000;

    // Reset state
    Hreset = 1'b1; Hreadyin = 1'b1; Hwrite = 1'b0; Htrans = HTRANS_IDLE;
    Haddr = '0; Hwdata = '0; apb_done = 1'b0; apb_err = 1'b0; apb_rdata = '0;
    repeat (2) @(posedge Hclk);
    #1;
    check("rst hreadyout", 64'(Hreadyout), 64'(1));
    check("rst hresp",     64'(Hresp), 64'(HRESP_OKAY));
    check("rst hrdata",    64'(Hrdata), 64'(0));
    check("rst req",       64'({req_valid, req_write, req_sel}), 64'(0));
    check("rst req_addr",  64'(req_addr), 64'(0));
    check("rst req_wdata", 64'(req_wdata), 64'(0));
    Hreset = 1'b0;
    @(posedge Hclk); #1;
    hrdata_model = '0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_xfer(vecs[i].name, vecs[i].addr, vecs[i].write, HTRANS_NONSEQ, vecs[i].wdata,
              vecs[i].delay, vecs[i].err, vecs[i].rdata, vecs[i].exp);
      hrdata_model = vecs[i].exp.hrdata;
    end

    // Back-to-back reads: second address presented in the S_RESP cycle
    drive_addr(32'h8400_0020, 1'b0, HTRANS_NONSEQ);
    run_data(32'h0, 1, 1'b0, 32'h0A0B_0C0D, o);
    e = model(32'h8400_0020, 1'b0, 1, 1'b0, 32'h0A0B_0C0D, hrdata_model);
    compare_obs("b2b_a", o, e, 32'h8400_0020, 1'b0, 32'h0);
    hrdata_model = e.hrdata;
    drive_addr(32'h8000_0100, 1'b0, HTRANS_SEQ);
    run_data(32'h0, 0, 1'b0, 32'h1122_3344, o);
    e = model(32'h8000_0100, 1'b0, 0, 1'b0, 32'h1122_3344, hrdata_model);
    compare_obs("b2b_b", o, e, 32'h8000_0100, 1'b0, 32'h0);
    hrdata_model = e.hrdata;
    // BUSY presented in S_RESP is ignored
    drive_addr(32'h8400_0000, 1'b0, HTRANS_BUSY);
    @(posedge Hclk); #1;
    check("busy ignored", 64'({Hreadyout, Hresp, req_valid}), 64'({1'b1, HRESP_OKAY, 1'b0}));
    // NONSEQ with Hreadyin low is not accepted
    Htrans = HTRANS_NONSEQ; Hreadyin = 1'b0;
    @(posedge Hclk); #1;
    check("hreadyin low", 64'({Hreadyout, Hresp, req_valid}), 64'({1'b1, HRESP_OKAY, 1'b0}));
    Hreadyin = 1'b1; Htrans = HTRANS_IDLE;
    @(posedge Hclk); #1;

    // New transfer accepted in S_ERR2
    drive_addr(32'h9000_0000, 1'b0, HTRANS_NONSEQ);
    run_data(32'h0, 0, 1'b0, 32'h0, o);
    e = model(32'h9000_0000, 1'b0, 0, 1'b0, 32'h0, hrdata_model);
    compare_obs("err2_a", o, e, 32'h9000_0000, 1'b0, 32'h0);
    drive_addr(32'h8800_0040, 1'b0, HTRANS_NONSEQ);
    run_data(32'h0, 2, 1'b0, 32'h7777_0001, o);
    e = model(32'h8800_0040, 1'b0, 2, 1'b0, 32'h7777_0001, hrdata_model);
    compare_obs("err2_b", o, e, 32'h8800_0040, 1'b0, 32'h0);
    hrdata_model = e.hrdata;
    Htrans = HTRANS_IDLE;
    @(posedge Hclk); #1;

    // Reset in S_WAIT with a completion pending, then a stray late completion
    drive_addr(32'h8000_0040, 1'b0, HTRANS_NONSEQ);
    @(posedge Hclk); #1;
    Htrans = HTRANS_IDLE;
    check("rstwait pre", 64'(req_valid), 64'(1));
    Hreset = 1'b1; apb_done = 1'b1; apb_err = 1'b0; apb_rdata = 32'hBAD0_BAD0;
    @(posedge Hclk); #1;
    check("rstwait out",    64'({req_valid, Hreadyout, Hresp}), 64'({1'b0, 1'b1, HRESP_OKAY}));
    check("rstwait hrdata", 64'(Hrdata), 64'(0));
    check("rstwait req",    64'({req_sel, req_addr}), 64'(0));
    Hreset = 1'b0;
    @(posedge Hclk); #1;
    apb_done = 1'b0;
    check("late done", 64'({req_valid, Hreadyout, Hresp, Hrdata}),
          64'({1'b0, 1'b1, HRESP_OKAY, 32'h0}));
    hrdata_model = '0;

    // Randomized transfers against the reference model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = BASE + $urandom_range(0, 32'h0BFF_FFFF);
        1:       addr = $urandom();
        2:       addr = edges[$urandom_range(0, 5)];
        default: addr = BASE + ($urandom_range(0, 2) << 26) + {$urandom_range(0, 15), 2'b00};
      endcase
      write = 1'($urandom_range(0, 1));
      wdata = $urandom();
      rdata = $urandom();
      delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      err   = ($urandom_range(0, 5) == 0);
      trans = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      e = model(addr, write, delay, err, rdata, hrdata_model);
      do_xfer($sformatf("rnd%0d", n), addr, write, trans, wdata, delay, err, rdata, e);
      hrdata_model = e.hrdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
